// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline writeback stage and a long-latency unit (LU).
// The pipeline has priority. LU results wait in a small FIFO and drain into
// idle write-port cycles. An aging counter bounds how long a live head entry
// can starve: once it expires, the head is forced out and the pipeline
// writeback is stalled for one cycle.
// Optional feature: define WB_ARB_BYPASS_EN to write an LU result straight to
// the register file when the buffer is empty and the pipeline is idle.
module wb_port_arbiter #(
  parameter int DW       = 18,
  parameter int AW       = 4,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWriteW,
  input  logic [AW-1:0] RdW,
  input  logic [DW-1:0] ResultW,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  output logic          stall_o,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wd,
  output logic          lu_pending
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  DepthC   = CW'(DEPTH);
  localparam logic [AGW-1:0] MaxWaitC = AGW'(MAX_WAIT);

  // Buffer storage: live bits are state, rd/data are plain payload.
  logic [DEPTH-1:0] liveQ, liveNext;
  logic [AW-1:0]    rdMem   [DEPTH];
  logic [DW-1:0]    dataMem [DEPTH];
  logic [PW-1:0]    headPtr, tailPtr;
  logic [CW-1:0]    count;
  logic [AGW-1:0]   age;

  logic nonEmpty, headLive, forceDrain, canAccept, bypass;
  logic pipeWrite, headWrite, doPop, doEnq;

  assign nonEmpty   = (count != '0);
  assign headLive   = nonEmpty && liveQ[headPtr];
  assign forceDrain = headLive && (age >= MaxWaitC);
  // Space is judged from registered state only; a same-cycle pop frees nothing.
  assign canAccept  = (count < DepthC);

`ifdef WB_ARB_BYPASS_EN
  // Empty buffer and idle pipeline: the LU result goes straight to the port.
  assign bypass = !nonEmpty && !RegWriteW && lu_valid;
`else
  assign bypass = 1'b0;
`endif

  // Pipeline wins unless the head has aged out. Any cycle the pipeline does not
  // write pops the head, writing it only if it is still live.
  assign pipeWrite = RegWriteW && !forceDrain;
  assign headWrite = !pipeWrite && !bypass && headLive;
  assign doPop     = !pipeWrite && nonEmpty;
  assign doEnq     = lu_valid && canAccept && !bypass;

  // Next live bits: WAW kill first, then pop, then the (younger) enqueue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    liveNext = liveQ;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipeWrite && (rdMem[i] == RdW)) liveNext[i] = 1'b0;
    end
    if (doPop) liveNext[headPtr] = 1'b0;
    if (doEnq) liveNext[tailPtr] = 1'b1;
  end

  // Control state: live bits, pointers, occupancy and head age.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      liveQ   <= '0;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      age     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      liveQ <= liveNext;
      if (doPop) headPtr <= headPtr + PW'(1);
      if (doEnq) tailPtr <= tailPtr + PW'(1);
      case ({doEnq, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (doPop || !nonEmpty) age <= '0;
      else if (age < MaxWaitC) age <= age + AGW'(1);
    end
  end

  // Payload capture on enqueue.
  always_ff @(posedge clk) begin
    // NOTE: payload RAM is not reset; the live bits alone decide whether a slot matters.
    if (doEnq) begin
      rdMem[tailPtr]   <= lu_rd;
      dataMem[tailPtr] <= lu_data;
    end
  end

  // Write-port mux and status outputs, all forced quiet while in reset.
  always_comb begin
    lu_ready   = 1'b0;
    stall_o    = 1'b0;
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_wd      = '0;
    lu_pending = 1'b0;
    if (!rst) begin
      lu_ready   = canAccept;
      stall_o    = forceDrain && RegWriteW;
      // Free slots always hold live=0 (cleared on pop), so OR-ing all bits is exact.
      lu_pending = |liveQ;
      if (pipeWrite) begin
        rf_we   = 1'b1;
        rf_addr = RdW;
        rf_wd   = ResultW;
      end else if (bypass) begin
        rf_we   = 1'b1;
        rf_addr = lu_rd;
        rf_wd   = lu_data;
      end else if (headWrite) begin
        rf_we   = 1'b1;
        rf_addr = rdMem[headPtr];
        rf_wd   = dataMem[headPtr];
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by randomized
// traffic. The driver runs a queue-based reference model each cycle and pushes
// the expected outputs; a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

  localparam int DW       = 18;
  localparam int AW       = 4;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RegWriteW = 1'b0;
  logic [AW-1:0] RdW = '0;
  logic [DW-1:0] ResultW = '0;
  logic          lu_valid = 1'b0;
  logic [AW-1:0] lu_rd = '0;
  logic [DW-1:0] lu_data = '0;
  logic          lu_ready, stall_o, rf_we, lu_pending;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wd;

  wb_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .stall_o(stall_o), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
    .lu_pending(lu_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            live;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    int            cyc;
    bit            inRst;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            stall;
    bit            ready;
    bit            pending;
  } exp_t;

  ent_t mq[$];
  int   mAge = 0;
  exp_t expQ[$];

  int errors = 0;
  int checks = 0;
  int cycNum = 0;
  bit lastAccept = 0;
  bit lastStall = 0;
  int stallCount = 0;
  int lastStallCyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic drive(input bit r, input bit rw, input logic [AW-1:0] rd,
                       input logic [DW-1:0] res, input bit lv,
                       input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    exp_t e;
    bit   frc, pipe, pop, byp, accept;
    int   cnt;
    @(posedge clk);
    #1;
    rst = r; RegWriteW = rw; RdW = rd; ResultW = res;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    cycNum++;
    e = '{default: 0};
    e.cyc = cycNum;
    e.inRst = r;
    lastAccept = 0;
    lastStall = 0;
    if (r) begin
      mq.delete();
      mAge = 0;
    end else begin
      cnt = mq.size();
      frc = (cnt > 0) && mq[0].live && (mAge >= MAX_WAIT);
      byp = BYPASS && (cnt == 0) && !rw && lv;
      e.ready = (cnt < DEPTH);
      e.stall = frc && rw;
      foreach (mq[i]) if (mq[i].live) e.pending = 1;
      pipe = 0;
      pop = 0;
      if (rw && !frc) begin
        pipe = 1; e.we = 1; e.addr = rd; e.wd = res;
      end else if (byp) begin
        e.we = 1; e.addr = lrd; e.wd = ld;
      end else if (cnt > 0) begin
        pop = 1;
        if (mq[0].live) begin
          e.we = 1; e.addr = mq[0].rd; e.wd = mq[0].data;
        end
      end
      accept = lv && e.ready;
      lastAccept = accept;
      lastStall = e.stall;
      if (pop || cnt == 0) mAge = 0;
      else if (mAge < MAX_WAIT) mAge = mAge + 1;
      if (pipe) foreach (mq[i]) if (mq[i].rd == rd) mq[i].live = 0;
      if (pop) void'(mq.pop_front());
      if (accept && !byp) mq.push_back('{1'b1, lrd, ld});
    end
    expQ.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the expected entry for each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check($sformatf("rf_we@%0d", e.cyc), rf_we, e.we);
      if (e.we || e.inRst) begin
        check($sformatf("rf_addr@%0d", e.cyc), rf_addr, e.addr);
        check($sformatf("rf_wd@%0d", e.cyc), rf_wd, e.wd);
      end
      check($sformatf("stall_o@%0d", e.cyc), stall_o, e.stall);
      check($sformatf("lu_ready@%0d", e.cyc), lu_ready, e.ready);
      check($sformatf("lu_pending@%0d", e.cyc), lu_pending, e.pending);
      if (stall_o === 1'b1) begin
        stallCount++;
        lastStallCyc = e.cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            enqCyc, snap, idx, rwPct;
    logic [AW-1:0] fullRd [3];
    bit            luHave, pw;
    logic [AW-1:0] luRd, prd;
    logic [DW-1:0] luData, pres;

    // Reset, then fill to count=2 and reset mid-stream.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'd1, 18'h00001, 1, 4'd2, 18'h00022);
    drive(0, 1, 4'd1, 18'h00002, 1, 4'd4, 18'h00044);
    drive(1, 1, 4'd1, 18'h00003, 0, 0, 0);
    drive(0, 1, 4'd3, 18'h000AB, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Idle drain of an all-ones payload.
    drive(0, 0, 0, 0, 1, 4'd5, 18'h3FFFF);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Starvation: pipeline writes every cycle after an enqueue of rd=7.
    snap = stallCount;
    drive(0, 1, 4'd1, 18'h00100, 1, 4'd7, 18'h00777);
    enqCyc = cycNum;
    repeat (7) drive(0, 1, 4'd1, 18'h00100, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("starve_stall_count", stallCount - snap, 1);
    check("starve_stall_delay", lastStallCyc - enqCyc, 5);

    // Full: three LU results offered while the pipeline writes continuously.
    fullRd[0] = 4'd10; fullRd[1] = 4'd11; fullRd[2] = 4'd12;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 4'd2, DW'(18'h02000 + k), idx < 3, fullRd[idx % 3], DW'(18'h1000 + idx));
      if (lastAccept) idx++;
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, idx < 3, fullRd[idx % 3], DW'(18'h1000 + idx));
      if (lastAccept) idx++;
    end
    check("full_all_accepted", idx, 3);

    // WAW: same-cycle commit does not kill; a later commit does.
    drive(0, 1, 4'd9, 18'h00099, 1, 4'd9, 18'h09999);
    drive(0, 1, 4'd9, 18'h00098, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Simultaneous pop and enqueue at count=1.
    drive(0, 1, 4'd1, 18'h00011, 1, 4'd6, 18'h00666);
    drive(0, 0, 0, 0, 1, 4'd8, 18'h00888);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with LU hold and pipeline hold under stall.
    luHave = 0; pw = 0; prd = '0; pres = '0; luRd = '0; luData = '0;
    for (int n = 0; n < 3000; n++) begin
      rwPct = (n < 1000) ? 30 : (n < 2000) ? 70 : 97;
      if ($urandom_range(0, 249) == 0) begin
        drive(1, pw, prd, pres, luHave, luRd, luData);
        continue;
      end
      if (!lastStall) begin
        pw   = ($urandom_range(0, 99) < rwPct);
        prd  = AW'($urandom_range(0, (n % 2 == 1) ? 3 : 15));
        pres = DW'($urandom);
      end
      if (!luHave && $urandom_range(0, 99) < 50) begin
        luHave = 1;
        luRd   = AW'($urandom_range(0, 7));
        luData = DW'($urandom);
      end
      drive(0, pw, prd, pres, luHave, luRd, luData);
      if (lastAccept) luHave = 0;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (LU), such as a multi-cycle multiply/divide or a late load.
- The pipeline has priority. LU results are buffered in a small FIFO and drained into idle write-port cycles.
- An aging counter bounds LU starvation by stalling the pipeline writeback for one cycle.
- Sits between the writeback result mux, the LU and the register file; it also drives the hazard unit's stall input.

Parameters:
- DW, 18, data width
- AW, 4, register address width
- DEPTH, 2, LU buffer entries (power of 2, ≥2)
- MAX_WAIT, 4, cycles a non-empty buffer head may wait before forced drain (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- RegWriteW  in  1  pipeline writeback request
- RdW  in  AW  pipeline destination register
- ResultW  in  DW  pipeline write data
- lu_valid  in  1  LU result valid
- lu_rd  in  AW  LU destination register
- lu_data  in  DW  LU result
- lu_ready  out  1  buffer can accept; lu_valid&&lu_ready = enqueue
- stall_o  out  1  freeze W stage and upstream this cycle
- rf_we  out  1  register-file write enable
- rf_addr  out  AW  write address
- rf_wd  out  DW  write data
- lu_pending  out  1  buffer holds ≥1 live entry (used by the hazard unit for RAW interlock)

Behaviour:
- Reset (async, rst=1): buffer empty, all valid/live bits cleared, age=0. While in reset: lu_ready=0, stall_o=0, rf_we=0, rf_addr=0, rf_wd=0, lu_pending=0.
- State: FIFO of DEPTH entries {live, rd, data}, a registered count, and age (counter, width clog2(MAX_WAIT+1)).
- lu_ready = (count < DEPTH). It is registered-state only; a same-cycle pop does not free a slot.
- force = (count≠0) && head.live && (age ≥ MAX_WAIT).
- Grant (combinational, zero latency):
  - If RegWriteW && !force: pipeline write. rf_we=1, rf_addr=RdW, rf_wd=ResultW.
  - Else if head.live: head write and pop. rf_we=1, rf_addr=head.rd, rf_wd=head.data.
  - Else if count≠0 && !head.live: pop the dead head with no write.
  - Else: rf_we=0.
- stall_o = force && RegWriteW. The pipeline contract holds W-stage values stable while stall_o=1; the held write commits on the next cycle.
- Age:
  - Reset to 0 on any pop or when count=0.
  - Otherwise increments once per cycle, saturating at MAX_WAIT.
  - So the maximum LU wait is MAX_WAIT+1 cycles after the entry reaches the head.
- WAW kill: when a pipeline write commits to RdW, every buffered entry with rd==RdW clears its live bit. An entry enqueued in the same cycle is younger than the commit and is not killed.
- Dead entries consume one pop cycle each and never drive rf_we.
- Enqueue and pop in the same cycle are allowed; count is unchanged.
- Full: lu_valid with lu_ready=0 is ignored. The LU must hold its result.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-operation discards buffered entries; no partial write is issued.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: when count=0, RegWriteW=0 and lu_valid=1, the LU result is written directly that cycle (rf_we=1, rf_addr=lu_rd, rf_wd=lu_data) and is not enqueued. LU-to-RF latency is 0.
- Undefined: every LU result is enqueued first. Minimum LU-to-RF latency is 1 cycle.

Test Plan:
- Reset check: assert rst mid-stream with count=2 → next cycle rf_we=0, lu_ready=0, lu_pending=0. After release, lu_ready=1 and the first pipeline write RdW=3, ResultW=18'h00AB gives rf_we=1, rf_addr=3, rf_wd=18'h00AB the same cycle.
- Idle drain: enqueue lu_rd=5, lu_data=18'h3FFFF with the pipeline idle → next cycle rf_we=1, rf_addr=5, rf_wd=18'h3FFFF; lu_pending then drops to 0. With the macro defined, the write occurs in the enqueue cycle.
- Starvation: enqueue rd=7, then hold RegWriteW=1 continuously, MAX_WAIT=4 → stall_o=1 exactly once, 5 cycles after enqueue. That cycle writes rf_addr=7; the held pipeline write follows next cycle.
- Full: enqueue 2 entries while the pipeline writes continuously → lu_ready=0. A third lu_valid is not accepted until a pop occurs.
- WAW: buffer holds rd=9; the pipeline commits RdW=9 → the entry is killed. The later drain cycle shows rf_we=0 and count decrements.
- Simultaneous: count=1 with the head drained in the same cycle as a new enqueue → count stays 1, age=0, and both entries are written in order.
